// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the set-2 scan-code byte stream from the PS/2 receiver into key
//   events. It strips the E0 (extended) and F0 (break) prefixes, drops
//   keyboard status bytes and queues one event per make/break in a
//   first-word-fall-through FIFO. Hex-digit keys are also translated to a
//   4-bit value.
//
//   State table
//     state       | meaning
//     S_IDLE      | no prefix pending
//     S_GOT_E0    | E0 seen, waiting for the code byte or F0
//     S_GOT_F0    | F0 seen, next code byte is a release
//     S_GOT_E0F0  | E0 F0 seen, next code byte is an extended release
//
// Ports
//   Clock       in   system clock, posedge
//   Reset       in   async active-high reset
//   iByteValid  in   one-cycle strobe qualifying iByte
//   iByte       in   received scan-code byte
//   iRead       in   pop the head event (ignored when empty)
//   oKeyValid   out  FIFO non-empty, head event on the outputs below
//   oKeyCode    out  head scan code with prefixes stripped
//   oBreak      out  head event is a release
//   oExtended   out  head event carried E0
//   oIsHex      out  head is a non-extended hex-digit key
//   oHexValue   out  hex value of the head (0 when oIsHex=0)
//   oCount      out  number of queued events
//   oOverflow   out  sticky: an event was dropped on a full FIFO
module ps2_scancode_decoder #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     iByteValid,
    input  logic [7:0]               iByte,
    input  logic                     iRead,
    output logic                     oKeyValid,
    output logic [7:0]               oKeyCode,
    output logic                     oBreak,
    output logic                     oExtended,
    output logic                     oIsHex,
    output logic [3:0]               oHexValue,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GOT_E0   = 2'd1,
        S_GOT_F0   = 2'd2,
        S_GOT_E0F0 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     count_q;
    logic            overflow_q;
    // Entry layout: {extended, break, code}
    logic [9:0]      mem_q [DEPTH];

    logic            is_status, is_e0, is_f0;
    logic            push, pop, full, do_write, drop;
    logic [9:0]      new_ev, head;
    logic            hex_hit;
    logic [3:0]      hex_val;

    always_comb begin
        is_status = (iByte == 8'hAA) || (iByte == 8'hFA) || (iByte == 8'hFE) ||
                    (iByte == 8'hEE) || (iByte == 8'h00) || (iByte == 8'hFF);
        is_e0     = (iByte == 8'hE0);
        is_f0     = (iByte == 8'hF0);
        push      = iByteValid && !is_status && !is_e0 && !is_f0;
        new_ev    = {(state_q == S_GOT_E0) || (state_q == S_GOT_E0F0),
                     (state_q == S_GOT_F0) || (state_q == S_GOT_E0F0),
                     iByte};
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = iRead && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_write  = push && (!full || pop);
        drop      = push && full && !pop;

        state_d = state_q;
        tmo_d   = tmo_q;
        if (iByteValid) begin
            tmo_d = '0;
            if (is_status) begin
                state_d = S_IDLE;
            end else if (is_e0) begin
                state_d = S_GOT_E0;
            end else if (is_f0) begin
                case (state_q)
                    S_IDLE:   state_d = S_GOT_F0;
                    S_GOT_E0: state_d = S_GOT_E0F0;
                    default:  state_d = state_q;
                endcase
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (do_write) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_write, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage carries no reset; stale entries are hidden by the pointers/count.
    always_ff @(posedge Clock) begin
        if (do_write) mem_q[wr_ptr_q] <= new_ev;
    end

    always_comb begin
        head    = mem_q[rd_ptr_q];
        hex_hit = 1'b1;
        hex_val = 4'h0;
        case (head[7:0])
            8'h45: hex_val = 4'h0;
            8'h16: hex_val = 4'h1;
            8'h1E: hex_val = 4'h2;
            8'h26: hex_val = 4'h3;
            8'h25: hex_val = 4'h4;
            8'h2E: hex_val = 4'h5;
            8'h36: hex_val = 4'h6;
            8'h3D: hex_val = 4'h7;
            8'h3E: hex_val = 4'h8;
            8'h46: hex_val = 4'h9;
            8'h1C: hex_val = 4'hA;
            8'h32: hex_val = 4'hB;
            8'h21: hex_val = 4'hC;
            8'h23: hex_val = 4'hD;
            8'h24: hex_val = 4'hE;
            8'h2B: hex_val = 4'hF;
            default: hex_hit = 1'b0;
        endcase
    end

    // Head fields are forced to zero while empty so reset/empty outputs are clean.
    assign oKeyValid = (count_q != '0);
    assign oKeyCode  = oKeyValid ? head[7:0] : 8'h00;
    assign oBreak    = oKeyValid && head[8];
    assign oExtended = oKeyValid && head[9];
    assign oIsHex    = oKeyValid && !head[9] && hex_hit;
    assign oHexValue = oIsHex ? hex_val : 4'h0;
    assign oCount    = count_q;
    assign oOverflow = overflow_q;

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver. Consumes its 8-bit scan-code bytes (set 2).
- Strips the E0 (extended) and F0 (break) prefixes and discards keyboard status bytes.
- Queues one key event per make/break in a FIFO with first-word-fall-through output.
- Translates hex-digit keys (0-9, A-F) to a 4-bit value so operands can be fed to the arithmetic blocks.

Parameters:
- DEPTH, 8, event FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 50000, max Clock cycles allowed between a prefix byte and its following byte (1 ms at 50 MHz).

Ports:
- Clock  in  1  system clock, all logic on posedge.
- Reset  in  1  asynchronous, active-high; clears state, FIFO, flags.
- iByteValid  in  1  one-cycle strobe; iByte is a complete received scan-code byte.
- iByte  in  8  scan-code byte from the receiver.
- iRead  in  1  pop request; honoured only when oKeyValid=1.
- oKeyValid  out  1  FIFO non-empty; head event is presented on the outputs below.
- oKeyCode  out  8  head event scan code, prefixes stripped.
- oBreak  out  1  head event is a key release.
- oExtended  out  1  head event carried an E0 prefix.
- oIsHex  out  1  head event is a non-extended hex-digit key.
- oHexValue  out  4  hex value of the head event; 0 when oIsHex=0.
- oCount  out  log2(DEPTH)+1  number of queued events.
- oOverflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (async, any time, including mid-prefix or mid-FIFO):
  - FSM returns to IDLE; FIFO is emptied; timeout counter cleared.
  - oKeyValid=0, oCount=0, oOverflow=0.
  - oKeyCode, oBreak, oExtended, oIsHex = 0; oHexValue = 0.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions are evaluated only on cycles with iByteValid=1.
- Status bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF: discarded in every state; next state is IDLE; no event.
- Byte 0xE0:
  - any state -> GOT_E0.
  - A prefix arriving in GOT_F0 or GOT_E0F0 restarts the sequence; the partial sequence is discarded.
- Byte 0xF0:
  - IDLE -> GOT_F0.
  - GOT_E0 -> GOT_E0F0.
  - GOT_F0 and GOT_E0F0 hold their state.
- Any other byte b:
  - pushes event {ext, brk, b}; ext=1 in GOT_E0/GOT_E0F0; brk=1 in GOT_F0/GOT_E0F0.
  - next state is IDLE.
- Timeout:
  - In any non-IDLE state the counter increments each cycle without iByteValid and resets to 0 on iByteValid.
  - When the counter reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE; no event.
  - The counter is held at 0 in IDLE.
- Latency: a terminating byte strobed at edge N is visible on oKeyValid/outputs after edge N (one cycle).
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Outputs are driven from the head entry.
  - oIsHex and oHexValue are decoded from the head entry.
- Pop: iRead=1 and oKeyValid=1 advances the head at the edge. iRead while empty is ignored, with no state change.
- Push and pop in the same cycle:
  - Both are performed; oCount is unchanged.
  - This also applies when the FIFO is full, so no drop and no overflow.
- Push while full without a pop: the event is dropped, oOverflow is set to 1 and stays 1 until Reset. FIFO contents are unchanged.
- Hex map (non-extended only, make or break):
  - Digits: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9.
  - Letters: 1C->A, 32->B, 21->C, 23->D, 24->E, 2B->F.
  - All other codes: oIsHex=0.
- Back-to-back strobes on consecutive cycles must be accepted, one byte per cycle.

Test Plan:
- Bytes 1C, F0, 1C, then pop twice:
  - event 1: oKeyCode=1C, oBreak=0, oIsHex=1, oHexValue=A.
  - event 2: oKeyCode=1C, oBreak=1.
  - afterwards oCount=0.
- Bytes E0, 75, E0, F0, 75:
  - two events, both oKeyCode=75, oExtended=1, oIsHex=0.
  - oBreak = 0 then 1.
- Bytes AA, FA, then E0 followed by FE:
  - no events; the FSM returns to IDLE.
  - a following 16 produces a single event: oKeyCode=16, oExtended=0, oHexValue=1.
- TIMEOUT_CYCLES=10:
  - F0, then 10 idle cycles, then 45: event oKeyCode=45, oBreak=0 (prefix expired).
  - repeating with 8 idle cycles gives oBreak=1.
- DEPTH=8:
  - 9 make codes with no reads: oCount=8, oOverflow=1, head equals the first code.
  - a push with a simultaneous pop at full: oCount stays 8 and the new code lands at the tail.
- Reset asserted asynchronously in GOT_E0F0 with 3 queued events:
  - oKeyValid=0 and oCount=0 immediately.
  - the next byte 16 yields oExtended=0, oBreak=0.
